// File: rtl/ils_instr_gen_pkg.sv
// Shared ISA constants, FSM state type and the instruction composer used by
// both the generator and the checker side of the harness.
package sodor_isa_pkg;

   localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
   localparam logic [6:0]  OPC_STORE  = 7'b0100011;
   localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

   localparam logic [2:0]  F3_SLL = 3'd1;
   localparam logic [2:0]  F3_SRX = 3'd5;
   localparam logic [2:0]  F3_LB  = 3'd0;
   localparam logic [2:0]  F3_LBU = 3'd4;
   localparam logic [2:0]  F3_SB  = 3'd0;

   // Galois taps for x^64+x^63+x^61+x^60+1, right-shifting form
   localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;

   typedef enum logic [1:0] {IDLE, WARMUP, GEN, DONE} gen_state_t;

   function automatic logic [63:0] lfsr_step(input logic [63:0] r);
      return (r >> 1) ^ (r[0] ? LFSR_MASK : 64'd0);
   endfunction

   // Map an LFSR state onto a legal OP-IMM / STORE / LOAD word.
   // Shift immediates are masked so SLLI/SRLI/SRAI stay encodable.
   function automatic logic [31:0] compose(input logic [63:0] r);
      logic [1:0]  sel;
      logic [2:0]  f3;
      logic [4:0]  rd, rs1, rs2;
      logic [11:0] imm, imm_m, imm_l;
      logic        lb;
      logic [31:0] w;
      sel   = r[1:0];
      f3    = r[4:2];
      rd    = r[9:5];
      rs1   = r[14:10];
      rs2   = r[19:15];
      imm   = r[31:20];
      imm_l = r[43:32];
      lb    = r[44];
      imm_m = imm;
      if (f3 == F3_SRX)
         imm_m = imm & 12'h41F;
      else if (f3 == F3_SLL)
         imm_m = imm & 12'h01F;
      if (sel[1])
         w = {imm_m, rs1, f3, rd, OPC_OP_IMM};
      else if (sel[0])
         w = {imm_l[11:5], rs2, rs1, F3_SB, imm_l[4:0], OPC_STORE};
      else
         w = {imm_l, rs1, (lb ? F3_LBU : F3_LB), rd, OPC_LOAD};
      return w;
   endfunction

endpackage

// File: rtl/ils_instr_gen_if.sv
// Instruction stream handshake: producer drives valid/data, consumer drives ready.
interface ils_instr_gen_if;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;

   modport master (output instr_valid, output instr_data, input instr_ready);
   modport slave  (input instr_valid, input instr_data, output instr_ready);
endinterface

// File: rtl/ils_instr_gen_lfsr64.sv
// 64-bit Galois LFSR; advances one step per enabled cycle, reloads seed on reset.
module lfsr64
   import sodor_isa_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        en,
   input  logic [63:0] seed,
   output logic [63:0] state
);

   logic [63:0] r_state;
   logic [63:0] w_seed_fixed;

   // An all-zero state would lock the register, so a zero seed becomes 1
   assign w_seed_fixed = (seed == 64'd0) ? 64'd1 : seed;

   // State register: reload on reset, step only when enabled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_state <= w_seed_fixed;
      else if (en)
         r_state <= lfsr_step(r_state);
   end

   assign state = r_state;

endmodule

// File: rtl/ils_instr_gen.sv
// Constrained-random I/L/S instruction source: NOP warm-up, then NUM_INSTR
// random words from an LFSR, all behind a stallable valid/ready output.
module ils_instr_gen
   import sodor_isa_pkg::*;
#(
   parameter logic [63:0] SEED        = 64'h0000_0000_0000_032D,
   parameter int          NUM_INSTR   = 100,
   parameter int          WARMUP_NOPS = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   ils_instr_gen_if.master      bus,
   output logic                 done,
   output logic [15:0]          count
);

   if (NUM_INSTR < 1 || NUM_INSTR > 65535) begin : g_bad_num_instr
      $error("ils_instr_gen: NUM_INSTR must be in 1..65535");
   end
   if (WARMUP_NOPS < 0 || WARMUP_NOPS > 255) begin : g_bad_warmup
      $error("ils_instr_gen: WARMUP_NOPS must be in 0..255");
   end

   localparam logic [7:0]  NOP_LAST = 8'((WARMUP_NOPS > 0) ? WARMUP_NOPS - 1 : 0);
   localparam logic [15:0] CNT_LAST = 16'(NUM_INSTR - 1);

   gen_state_t  r_state, w_state_next;
   logic        r_valid, w_valid_next;
   logic [31:0] r_data, w_data_next;
   logic        r_done, w_done_next;
   logic [15:0] r_count, w_count_next;
   logic [7:0]  r_nop, w_nop_next;
   logic        w_accept, w_lfsr_en;
   logic [63:0] w_lfsr, w_lfsr_next;

   assign w_accept    = r_valid & bus.instr_ready;
   assign w_lfsr_next = lfsr_step(w_lfsr);

   lfsr64 u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (w_lfsr_en),
      .seed    (SEED),
      .state   (w_lfsr)
   );

   // State and output registers; every output is driven straight from a flop
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_valid <= 1'b0;
         r_data  <= INSTR_NOP;
         r_done  <= 1'b0;
         r_count <= 16'd0;
         r_nop   <= 8'd0;
      end else begin
         r_state <= w_state_next;
         r_valid <= w_valid_next;
         r_data  <= w_data_next;
         r_done  <= w_done_next;
         r_count <= w_count_next;
         r_nop   <= w_nop_next;
      end
   end

   // Next-state/output logic; the data register only moves on an accept, so
   // a stalled word is held unchanged until the consumer takes it
   always_comb begin
      w_state_next = r_state;
      w_valid_next = r_valid;
      w_data_next  = r_data;
      w_done_next  = r_done;
      w_count_next = r_count;
      w_nop_next   = r_nop;
      w_lfsr_en    = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_done_next  = 1'b0;
               w_count_next = 16'd0;
               w_nop_next   = 8'd0;
               w_valid_next = 1'b1;
               if (WARMUP_NOPS == 0) begin
                  w_state_next = GEN;
                  w_data_next  = compose(w_lfsr);
               end else begin
                  w_state_next = WARMUP;
                  w_data_next  = INSTR_NOP;
               end
            end
         end
         WARMUP: begin
            if (w_accept) begin
               if (r_nop == NOP_LAST) begin
                  w_state_next = GEN;
                  w_data_next  = compose(w_lfsr);
               end else begin
                  w_nop_next = r_nop + 8'd1;
               end
            end
         end
         GEN: begin
            if (w_accept) begin
               w_lfsr_en    = 1'b1;
               w_count_next = r_count + 16'd1;
               if (r_count == CNT_LAST) begin
                  w_state_next = DONE;
                  w_valid_next = 1'b0;
                  w_done_next  = 1'b1;
               end else begin
                  w_data_next = compose(w_lfsr_next);
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign bus.instr_valid = r_valid;
   assign bus.instr_data  = r_data;
   assign done            = r_done;
   assign count           = r_count;

endmodule

// File: tb/tb_ils_instr_gen.sv
// Directed bench: dut_a (3 NOPs, 5 words) covers warm-up, done and run
// continuation; dut_b (no warm-up, 100 words) covers stall, legality and
// mid-run reset replay.
module tb_ils_instr_gen;

   logic        clk = 1'b0;
   logic        rst_a, rst_b, st_a, st_b;
   logic        done_a, done_b;
   logic [15:0] cnt_a, cnt_b;
   int          n_vec = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   ils_instr_gen_if bus_a ();
   ils_instr_gen_if bus_b ();

   ils_instr_gen #(.SEED(64'h32D), .NUM_INSTR(5), .WARMUP_NOPS(3)) dut_a (
      .clk(clk), .reset_n(rst_a), .start(st_a), .bus(bus_a), .done(done_a), .count(cnt_a));

   ils_instr_gen #(.SEED(64'h32D), .NUM_INSTR(100), .WARMUP_NOPS(0)) dut_b (
      .clk(clk), .reset_n(rst_b), .start(st_b), .bus(bus_b), .done(done_b), .count(cnt_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference LFSR step and word composition, written from the field map
   function automatic logic [63:0] m_step(input logic [63:0] r);
      logic [63:0] n;
      n = {1'b0, r[63:1]};
      if (r[0]) n = n ^ 64'hD800_0000_0000_0000;
      return n;
   endfunction

   function automatic logic [31:0] m_word(input logic [63:0] r);
      logic [2:0]  f3;
      logic [11:0] imm;
      logic [31:0] w;
      f3  = r[4:2];
      imm = r[31:20];
      case (r[1:0])
         2'b00:   w = {r[43:32], r[14:10], r[44], 2'b00, r[9:5], 7'h03};
         2'b01:   w = {r[43:37], r[19:15], r[14:10], 3'b000, r[36:32], 7'h23};
         default: begin
            if (f3 == 3'd5)      imm = imm & 12'h41F;
            else if (f3 == 3'd1) imm = imm & 12'h01F;
            w = {imm, r[14:10], f3, r[9:5], 7'h13};
         end
      endcase
      return w;
   endfunction

   function automatic logic legal(input logic [31:0] w);
      logic ok;
      case (w[6:0])
         7'h13: begin
            if (w[14:12] == 3'd5)      ok = (w[31] == 1'b0) && (w[29:25] == 5'd0);
            else if (w[14:12] == 3'd1) ok = (w[31:25] == 7'd0);
            else                       ok = 1'b1;
         end
         7'h03:   ok = (w[14:12] == 3'd0) || (w[14:12] == 3'd4);
         7'h23:   ok = (w[14:12] == 3'd0);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   initial begin
      logic [63:0] ma, mb;
      logic [31:0] exp_w, last_w;
      logic [31:0] run1 [0:37];

      // Reset held, start asserted during reset must be ignored
      rst_a = 1'b0; rst_b = 1'b0; st_a = 1'b1; st_b = 1'b1;
      bus_a.instr_ready = 1'b0; bus_b.instr_ready = 1'b0;
      repeat (3) tick();
      chk("rst_valid", 32'(bus_a.instr_valid), 32'd0);
      chk("rst_data",  bus_a.instr_data, 32'h0000_0013);
      chk("rst_count", 32'(cnt_a), 32'd0);
      chk("rst_done",  32'(done_a), 32'd0);
      st_a = 1'b0; st_b = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
      tick(); tick();
      chk("idle_valid", 32'(bus_a.instr_valid), 32'd0);

      // dut_a run 1: three NOPs then five words
      bus_a.instr_ready = 1'b1; st_a = 1'b1; tick(); st_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("a_nop_valid", 32'(bus_a.instr_valid), 32'd1);
         chk("a_nop_data", bus_a.instr_data, 32'h0000_0013);
         tick();
      end
      chk("a_gen0_hand", bus_a.instr_data, 32'h0000_0023);
      ma = 64'h32D;
      last_w = 32'd0;
      for (int k = 0; k < 5; k++) begin
         exp_w = m_word(ma);
         chk("a_word", bus_a.instr_data, exp_w);
         chk("a_count", 32'(cnt_a), 32'(k));
         chk("a_done_low", 32'(done_a), 32'd0);
         if (k == 1) chk("a_gen1_hand", bus_a.instr_data, 32'h0000_5613);
         if (k == 2) chk("a_gen2_hand", bus_a.instr_data, 32'h0000_2313);
         last_w = exp_w;
         ma = m_step(ma);
         tick();
      end
      chk("a_done", 32'(done_a), 32'd1);
      chk("a_done_valid", 32'(bus_a.instr_valid), 32'd0);
      chk("a_done_count", 32'(cnt_a), 32'd5);
      chk("a_done_hold", bus_a.instr_data, last_w);

      // dut_a run 2: LFSR continues; start pulses in WARMUP/GEN are ignored
      st_a = 1'b1; tick(); st_a = 1'b0;
      chk("a2_count0", 32'(cnt_a), 32'd0);
      chk("a2_done0", 32'(done_a), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("a2_nop_data", bus_a.instr_data, 32'h0000_0013);
         st_a = (i == 1);
         tick();
      end
      st_a = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("a2_word", bus_a.instr_data, m_word(ma));
         chk("a2_count", 32'(cnt_a), 32'(k));
         st_a = (k == 2);
         ma = m_step(ma);
         tick();
      end
      st_a = 1'b0;
      chk("a2_done", 32'(done_a), 32'd1);
      chk("a2_count_end", 32'(cnt_a), 32'd5);

      // dut_b: zero warm-up, stall at word 10, reset at count 37
      bus_b.instr_ready = 1'b1; st_b = 1'b1; tick(); st_b = 1'b0;
      chk("b_first_hand", bus_b.instr_data, 32'h0000_0023);
      mb = 64'h32D;
      for (int k = 0; k < 37; k++) begin
         exp_w = m_word(mb);
         if (k == 10) begin
            bus_b.instr_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               tick();
               chk("b_stall_data", bus_b.instr_data, exp_w);
               chk("b_stall_valid", 32'(bus_b.instr_valid), 32'd1);
               chk("b_stall_count", 32'(cnt_b), 32'd10);
            end
            bus_b.instr_ready = 1'b1;
         end
         chk("b_word", bus_b.instr_data, exp_w);
         chk("b_legal", 32'(legal(bus_b.instr_data)), 32'd1);
         run1[k] = bus_b.instr_data;
         mb = m_step(mb);
         tick();
      end
      chk("b_count37", 32'(cnt_b), 32'd37);
      run1[37] = bus_b.instr_data;
      rst_b = 1'b0;
      #1;
      chk("b_async_valid", 32'(bus_b.instr_valid), 32'd0);
      chk("b_async_data", bus_b.instr_data, 32'h0000_0013);
      chk("b_async_count", 32'(cnt_b), 32'd0);
      tick(); rst_b = 1'b1; tick();
      st_b = 1'b1; tick(); st_b = 1'b0;
      for (int k = 0; k < 38; k++) begin
         chk("b_replay", bus_b.instr_data, run1[k]);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
